// File: rtl/ebr_ram_arbiter_if.sv
// Request, response and RAM pin bundle for ebr_ram_arbiter.
// Signal directions are named from the arbiter's point of view.
interface ebr_ram_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              i_req0_valid;
    logic              i_req0_write;
    logic [ADDR_W-1:0] i_req0_addr;
    logic [WIDTH-1:0]  i_req0_data;
    logic              o_req0_ready;
    logic              i_req1_valid;
    logic              i_req1_write;
    logic [ADDR_W-1:0] i_req1_addr;
    logic [WIDTH-1:0]  i_req1_data;
    logic              o_req1_ready;
    logic [WIDTH-1:0]  o_rsp0_data;
    logic              o_rsp0_valid;
    logic [WIDTH-1:0]  o_rsp1_data;
    logic              o_rsp1_valid;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [WIDTH-1:0]  o_ram_wdata;
    logic              o_ram_we;
    logic              o_ram_re;
    logic [WIDTH-1:0]  i_ram_rdata;

    modport slave (
        input  i_req0_valid, i_req0_write, i_req0_addr, i_req0_data,
        input  i_req1_valid, i_req1_write, i_req1_addr, i_req1_data,
        input  i_ram_rdata,
        output o_req0_ready, o_req1_ready,
        output o_rsp0_data, o_rsp0_valid, o_rsp1_data, o_rsp1_valid,
        output o_ram_addr, o_ram_wdata, o_ram_we, o_ram_re
    );

    modport master (
        output i_req0_valid, i_req0_write, i_req0_addr, i_req0_data,
        output i_req1_valid, i_req1_write, i_req1_addr, i_req1_data,
        output i_ram_rdata,
        input  o_req0_ready, o_req1_ready,
        input  o_rsp0_data, o_rsp0_valid, o_rsp1_data, o_rsp1_valid,
        input  o_ram_addr, o_ram_wdata, o_ram_we, o_ram_re
    );
endinterface

// File: rtl/ebr_ram_arbiter.sv
// Round-robin two-requester arbiter in front of a single-port EBR RAM,
// with zero-fill after reset or on i_clear.
module ebr_ram_arbiter #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_clear,
    output logic               o_init_done,
    ebr_ram_arbiter_if.slave   bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              t1_vld_q, t1_vld_d;
    logic              t1_id_q, t1_id_d;
    logic              t2_vld_q, t2_id_q;
    logic              rsp0_vld_q, rsp1_vld_q;
    logic [WIDTH-1:0]  rsp0_data_q, rsp1_data_q;

    logic              run;
    logic              gnt0, gnt1;
    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [WIDTH-1:0]  acc_data;

    // i_clear blocks the grant in the same cycle it is sampled
    assign run  = (state_q == ST_RUN) && !i_clear;
    assign gnt0 = run && bus.i_req0_valid && (!bus.i_req1_valid || !ptr_q);
    assign gnt1 = run && bus.i_req1_valid && (!bus.i_req0_valid || ptr_q);

    assign acc_write = gnt1 ? bus.i_req1_write : bus.i_req0_write;
    assign acc_addr  = gnt1 ? bus.i_req1_addr  : bus.i_req0_addr;
    assign acc_data  = gnt1 ? bus.i_req1_data  : bus.i_req0_data;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        re_d     = 1'b0;
        t1_vld_d = 1'b0;
        t1_id_d  = t1_id_q;
        case (state_q)
            ST_CLEAR: begin
                we_d    = 1'b1;
                addr_d  = cnt_q;
                wdata_d = '0;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1))
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (i_clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else if (gnt0 || gnt1) begin
                    ptr_d    = gnt0;
                    addr_d   = acc_addr;
                    wdata_d  = acc_data;
                    we_d     = acc_write;
                    re_d     = !acc_write;
                    t1_vld_d = !acc_write;
                    t1_id_d  = gnt1;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_CLEAR;
            cnt_q    <= '0;
            ptr_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            t1_vld_q <= 1'b0;
            t1_id_q  <= 1'b0;
            t2_vld_q <= 1'b0;
            t2_id_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            re_q     <= re_d;
            t1_vld_q <= t1_vld_d;
            t1_id_q  <= t1_id_d;
            t2_vld_q <= t1_vld_q;
            t2_id_q  <= t1_id_q;
        end
    end

    // Read data lands one cycle after the RAM command; steer it by tag
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rsp0_vld_q  <= 1'b0;
            rsp1_vld_q  <= 1'b0;
            rsp0_data_q <= '0;
            rsp1_data_q <= '0;
        end else begin
            rsp0_vld_q <= t2_vld_q && !t2_id_q;
            rsp1_vld_q <= t2_vld_q && t2_id_q;
            if (t2_vld_q && !t2_id_q)
                rsp0_data_q <= bus.i_ram_rdata;
            if (t2_vld_q && t2_id_q)
                rsp1_data_q <= bus.i_ram_rdata;
        end
    end

    assign o_init_done      = (state_q == ST_RUN);
    assign bus.o_req0_ready = gnt0;
    assign bus.o_req1_ready = gnt1;
    assign bus.o_rsp0_valid = rsp0_vld_q;
    assign bus.o_rsp1_valid = rsp1_vld_q;
    assign bus.o_rsp0_data  = rsp0_data_q;
    assign bus.o_rsp1_data  = rsp1_data_q;
    assign bus.o_ram_addr   = addr_q;
    assign bus.o_ram_wdata  = wdata_q;
    assign bus.o_ram_we     = we_q;
    assign bus.o_ram_re     = re_q;
endmodule

// File: tb/tb_ebr_ram_arbiter.sv
// Randomized bench for ebr_ram_arbiter with a RAM model and a
// transaction-level reference (memory image, rr pointer, response queue).
module tb_ebr_ram_arbiter;
    localparam int WIDTH = 16;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    typedef struct {
        int              due;
        bit              id;
        logic [WIDTH-1:0] data;
    } rsp_t;

    logic clk;
    logic rst_n;
    logic clr;
    logic init_done;
    int   cyc;
    int   n_chk;
    int   n_pass;

    logic [WIDTH-1:0] ram [DEPTH];
    logic [WIDTH-1:0] rdata;

    bit               m_run;
    bit               m_ptr;
    logic [WIDTH-1:0] m_mem [DEPTH];
    logic [WIDTH-1:0] exp_d0;
    logic [WIDTH-1:0] exp_d1;
    rsp_t             rq[$];

    ebr_ram_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    ebr_ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clock    (clk),
        .i_reset_n  (rst_n),
        .i_clear    (clr),
        .o_init_done(init_done),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.o_ram_we)
            ram[bus.o_ram_addr] <= bus.o_ram_wdata;
        if (bus.o_ram_re)
            rdata <= ram[bus.o_ram_addr];
    end
    assign bus.i_ram_rdata = rdata;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic check_rsp();
        bit e0;
        bit e1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].id) begin
                e1 = 1'b1;
                exp_d1 = rq[0].data;
            end else begin
                e0 = 1'b1;
                exp_d0 = rq[0].data;
            end
            void'(rq.pop_front());
        end
        check("rsp0_valid", 32'(bus.o_rsp0_valid), 32'(e0));
        check("rsp1_valid", 32'(bus.o_rsp1_valid), 32'(e1));
        check("rsp0_data", 32'(bus.o_rsp0_data), 32'(exp_d0));
        check("rsp1_data", 32'(bus.o_rsp1_data), 32'(exp_d1));
    endtask

    task automatic run_cycle(input bit v0, input bit w0,
                             input logic [AW-1:0] a0, input logic [WIDTH-1:0] d0,
                             input bit v1, input bit w1,
                             input logic [AW-1:0] a1, input logic [WIDTH-1:0] d1,
                             input bit c);
        bit               g0, g1, acc, aw;
        logic [AW-1:0]    aa;
        logic [WIDTH-1:0] ad;
        logic [WIDTH-1:0] rv;
        bit               sel;
        bus.i_req0_valid = v0;
        bus.i_req0_write = w0;
        bus.i_req0_addr  = a0;
        bus.i_req0_data  = d0;
        bus.i_req1_valid = v1;
        bus.i_req1_write = w1;
        bus.i_req1_addr  = a1;
        bus.i_req1_data  = d1;
        clr = c;
        #2;
        g0 = m_run && !c && v0 && (!v1 || !m_ptr);
        g1 = m_run && !c && v1 && (!v0 || m_ptr);
        check("ready0", 32'(bus.o_req0_ready), 32'(g0));
        check("ready1", 32'(bus.o_req1_ready), 32'(g1));
        acc = g0 || g1;
        sel = g1;
        aw  = g1 ? w1 : w0;
        aa  = g1 ? a1 : a0;
        ad  = g1 ? d1 : d0;
        rv  = m_mem[aa];
        if (acc) begin
            m_ptr = g0;
            if (aw)
                m_mem[aa] = ad;
        end
        if (c && m_run)
            m_run = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b0;
        if (acc && !aw)
            rq.push_back('{due: cyc + 2, id: sel, data: rv});
        check("ram_we", 32'(bus.o_ram_we), 32'(acc && aw));
        check("ram_re", 32'(bus.o_ram_re), 32'(acc && !aw));
        if (acc)
            check("ram_addr", 32'(bus.o_ram_addr), 32'(aa));
        if (acc && aw)
            check("ram_wdata", 32'(bus.o_ram_wdata), 32'(ad));
        check_rsp();
        check("init_done", 32'(init_done), 32'(m_run));
    endtask

    task automatic idle();
        run_cycle(0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    task automatic wr(input bit p, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        if (p) run_cycle(0, 0, '0, '0, 1, 1, a, d, 0);
        else   run_cycle(1, 1, a, d, 0, 0, '0, '0, 0);
    endtask

    task automatic rd(input bit p, input logic [AW-1:0] a);
        if (p) run_cycle(0, 0, '0, '0, 1, 0, a, '0, 0);
        else   run_cycle(1, 0, a, '0, 0, 0, '0, '0, 0);
    endtask

    task automatic wait_clear();
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        bus.i_req0_valid = 1'b1;
        bus.i_req1_valid = 1'b1;
        bus.i_req0_write = 1'b1;
        bus.i_req1_write = 1'b0;
        for (int i = 0; i < DEPTH + 8 && !done; i++) begin
            @(posedge clk);
            #1;
            check_rsp();
            check("clr_re", 32'(bus.o_ram_re), 32'(0));
            if (bus.o_ram_we) begin
                check("clr_addr", 32'(bus.o_ram_addr), 32'(n));
                check("clr_wdata", 32'(bus.o_ram_wdata), 32'(0));
                n++;
            end else if (n > 0) begin
                check("clr_gap", 32'(bus.o_ram_we), 32'(1));
            end
            if (init_done) begin
                done = 1'b1;
            end else begin
                check("clr_ready0", 32'(bus.o_req0_ready), 32'(0));
                check("clr_ready1", 32'(bus.o_req1_ready), 32'(0));
            end
        end
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        check("clr_count", 32'(n), 32'(DEPTH));
        check("clr_done", 32'(init_done), 32'(1));
        m_run = 1'b1;
        foreach (m_mem[i]) m_mem[i] = '0;
    endtask

    task automatic do_reset();
        bus.i_req0_valid = 1'b1;
        bus.i_req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_init", 32'(init_done), 32'(0));
        check("rst_ready0", 32'(bus.o_req0_ready), 32'(0));
        check("rst_ready1", 32'(bus.o_req1_ready), 32'(0));
        check("rst_we", 32'(bus.o_ram_we), 32'(0));
        check("rst_re", 32'(bus.o_ram_re), 32'(0));
        check("rst_addr", 32'(bus.o_ram_addr), 32'(0));
        check("rst_wdata", 32'(bus.o_ram_wdata), 32'(0));
        check("rst_rsp0v", 32'(bus.o_rsp0_valid), 32'(0));
        check("rst_rsp1v", 32'(bus.o_rsp1_valid), 32'(0));
        check("rst_rsp0d", 32'(bus.o_rsp0_data), 32'(0));
        check("rst_rsp1d", 32'(bus.o_rsp1_data), 32'(0));
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_hold_rsp0v", 32'(bus.o_rsp0_valid), 32'(0));
            check("rst_hold_rsp1v", 32'(bus.o_rsp1_valid), 32'(0));
            check("rst_hold_we", 32'(bus.o_ram_we), 32'(0));
        end
        rq.delete();
        exp_d0 = '0;
        exp_d1 = '0;
        m_ptr  = 1'b0;
        m_run  = 1'b0;
        rst_n  = 1'b1;
        wait_clear();
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        clr    = 1'b0;
        bus.i_req0_valid = 1'b0;
        bus.i_req0_write = 1'b0;
        bus.i_req0_addr  = '0;
        bus.i_req0_data  = '0;
        bus.i_req1_valid = 1'b0;
        bus.i_req1_write = 1'b0;
        bus.i_req1_addr  = '0;
        bus.i_req1_data  = '0;
        do_reset();

        wr(0, 10'd5, 16'hA5A5);
        rd(0, 10'd5);
        repeat (3) idle();

        wr(0, 10'd1, 16'h1111);
        wr(1, 10'd2, 16'h2222);
        repeat (8) run_cycle(1, 0, 10'd1, '0, 1, 0, 10'd2, '0, 0);
        repeat (3) idle();

        rd(1, 10'd5);
        repeat (2) run_cycle(1, 0, 10'd1, '0, 1, 0, 10'd2, '0, 0);
        repeat (3) idle();

        rd(0, 10'd5);
        idle();
        do_reset();

        wr(0, 10'd7, 16'h00FF);
        rd(0, 10'd7);
        run_cycle(1, 1, 10'd7, 16'hDEAD, 1, 0, 10'd7, '0, 1);
        wait_clear();
        rd(1, 10'd7);
        repeat (3) idle();

        for (int i = 0; i < 800; i++) begin
            bit c;
            c = ($urandom_range(0, 299) == 0);
            run_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                      10'($urandom_range(0, 15)), 16'($urandom),
                      $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                      10'($urandom_range(0, 15)), 16'($urandom), c);
            if (c)
                wait_clear();
        end
        repeat (4) idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
